mem_recall: RTL and testbench



---
 rtl/mem_recall_if.sv | 26 ++
 rtl/mem_recall.sv | 111 +++++++++++
 tb/tb_mem_recall.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_recall_if.sv
// Write-strobe, recalled-value handshake and occupancy signals of mem_recall.
// master drives writes and out_ready; slave is the history buffer.
interface mem_recall_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [CntW-1:0]  count;
  logic             empty;

  modport master (
    output wr_en, wr_data, out_ready,
    input  out_data, out_valid, count, empty
  );

  modport slave (
    input  wr_en, wr_data, out_ready,
    output out_data, out_valid, count, empty
  );
endinterface

// File: rtl/mem_recall.sv
// Circular result history with button-driven backward recall onto a valid/ready output.
// Optional RECALL_CLEAR_EN adds a synchronous clr input that empties the history.
module mem_recall #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rec_btn,
`ifdef RECALL_CLEAR_EN
  input  logic         clr,
`endif
  mem_recall_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  offset_q, offset_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       sync_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_idx;
  logic             rec_pulse;
  logic             clr_s;

`ifdef RECALL_CLEAR_EN
  assign clr_s = clr;
`else
  assign clr_s = 1'b0;
`endif

  // sync_q[1:0] is the metastability pair; sync_q[2] delays for edge detection
  assign rec_pulse = sync_q[1] & ~sync_q[2];
  assign rd_idx    = wr_ptr_q - PtrW'(1) - offset_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // A write in the same idle cycle as the pulse makes the buffer non-empty in time
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (rec_pulse && (count_q != '0 || bus.wr_en)) state_d = StFetch;
      StFetch:   state_d = StPresent;
      StPresent: if (bus.out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (clr_s) state_d = StIdle;
  end

  always_comb begin
    bus.out_valid = (state_q == StPresent);
  end

  assign bus.out_data = out_data_q;
  assign bus.count    = count_q;
  assign bus.empty    = (count_q == '0);

  // Writes override the fetch's offset advance; clr overrides everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    offset_d   = offset_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    if (state_q == StFetch) begin
      out_data_d = mem_q[rd_idx];
      offset_d   = (CntW'(offset_q) + CntW'(1) == count_q) ? '0 : offset_q + PtrW'(1);
    end
    if (bus.wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      offset_d = '0;
      if (count_q != CntW'(DEPTH)) count_d = count_q + CntW'(1);
    end
    if (clr_s) begin
      wr_ptr_d = '0;
      offset_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      offset_q   <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      sync_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      offset_q   <= offset_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      sync_q     <= {sync_q[1:0], rec_btn};
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && !clr_s) mem_q[wr_ptr_q] <= bus.wr_data;
  end

endmodule

// File: tb/tb_mem_recall.sv
// Directed and randomized bench for mem_recall against a queue-based history model.
module tb_mem_recall;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 9;

  logic clk;
  logic rst;
  logic rec_btn;
`ifdef RECALL_CLEAR_EN
  logic clr;
`endif

  mem_recall_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  mem_recall #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .rec_btn (rec_btn),
`ifdef RECALL_CLEAR_EN
    .clr     (clr),
`endif
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference: newest value at the back of hist; off counts recalls since last write
  logic [WIDTH-1:0] hist[$];
  int               off;

  function automatic void m_write(input logic [WIDTH-1:0] v);
    hist.push_back(v);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    off = 0;
  endfunction

  function automatic logic [WIDTH-1:0] m_recall();
    logic [WIDTH-1:0] r;
    r   = hist[hist.size() - 1 - off];
    off = (off + 1) % hist.size();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    hist.delete();
    off = 0;
  endtask

  task automatic do_write(input logic [WIDTH-1:0] v);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    tick();
    bus.wr_en   = 1'b0;
    m_write(v);
  endtask

  // Press, wait for valid, hold for `stall` cycles with out_ready low, then accept
  task automatic recall_expect(input string tag, input int stall);
    logic [WIDTH-1:0] exp;
    int n;
    exp           = m_recall();
    bus.out_ready = (stall == 0);
    rec_btn       = 1'b1;
    n             = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    rec_btn = 1'b0;
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk(tag, bus.out_data, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_hold"}, {bus.out_valid, bus.out_data}, {1'b1, exp});
    end
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_drop"}, bus.out_valid, 0);
    repeat (3) tick();
  endtask

  initial begin
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] v;
    bit               seen;
    rst           = 1'b0;
    rec_btn       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.out_ready = 1'b1;
`ifdef RECALL_CLEAR_EN
    clr           = 1'b0;
`endif
    hist.delete();
    off = 0;

    #2 rst = 1'b1;
    #1;
    chk("rst_state", {bus.out_valid, bus.count, bus.empty, bus.out_data},
        {1'b0, 3'd0, 1'b1, 9'd0});
    tick();
    rst = 1'b0;

    // Recall on an empty buffer is ignored
    rec_btn = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 2) rec_btn = 1'b0;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("empty_recall_valid", {31'd0, seen}, 0);
    chk("empty_recall_cnt", {bus.count, bus.empty}, {3'd0, 1'b1});

    // Single write, exact recall latency
    do_write(9'h005);
    chk("wr1_cnt", {bus.count, bus.empty}, {3'd1, 1'b0});
    rec_btn = 1'b1;
    tick();
    chk("lat_n", bus.out_valid, 0);
    tick();
    chk("lat_n1", bus.out_valid, 0);
    tick();
    chk("lat_n2", bus.out_valid, 0);
    tick();
    rec_btn = 1'b0;
    chk("lat_n3", {bus.out_valid, bus.out_data}, {1'b1, 9'h005});
    tick();
    chk("lat_n4", bus.out_valid, 0);
    void'(m_recall());
    repeat (3) tick();

    // Wrap within a partly filled buffer
    do_reset();
    do_write(9'd1);
    do_write(9'd2);
    do_write(9'd3);
    for (int i = 0; i < 4; i++) recall_expect($sformatf("wrap%0d", i), 0);

    // Overwrite of oldest entry
    do_reset();
    for (int i = 10; i <= 14; i++) do_write(WIDTH'(i));
    chk("full_cnt", {bus.count, bus.empty}, {3'd4, 1'b0});
    for (int i = 0; i < 4; i++) recall_expect($sformatf("full%0d", i), 0);

    // Stall, write and dropped press during PRESENT
    bus.out_ready = 1'b0;
    d0            = m_recall();
    rec_btn       = 1'b1;
    for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) tick();
    rec_btn = 1'b0;
    chk("stall_first", {bus.out_valid, bus.out_data}, {1'b1, d0});
    repeat (3) tick();
    do_write(9'h1FF);
    chk("stall_after_wr", {bus.out_valid, bus.out_data}, {1'b1, d0});
    rec_btn = 1'b1;
    repeat (2) tick();
    rec_btn = 1'b0;
    repeat (4) tick();
    chk("stall_press_drop", {bus.out_valid, bus.out_data}, {1'b1, d0});
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release", bus.out_valid, 0);
    repeat (2) tick();
    recall_expect("after_stall", 0);

    // Write coinciding with rec_pulse in IDLE, starting from empty
    do_reset();
    rec_btn = 1'b1;
    tick();
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_data = 9'h0A7;
    tick();
    bus.wr_en = 1'b0;
    rec_btn   = 1'b0;
    m_write(9'h0A7);
    tick();
    chk("wr_pulse_same", {bus.out_valid, bus.out_data}, {1'b1, m_recall()});
    repeat (4) tick();

    // Randomized writes and stalled recalls
    for (int i = 0; i < 40; i++) begin
      if (hist.size() == 0 || $urandom_range(0, 2) == 0) begin
        v = WIDTH'($urandom);
        do_write(v);
        chk($sformatf("rnd_cnt%0d", i), bus.count, hist.size());
      end else begin
        recall_expect($sformatf("rnd_rec%0d", i), int'($urandom_range(0, 3)));
      end
    end

    // Asynchronous reset during FETCH and during PRESENT
    do_write(9'h033);
    rec_btn = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_fetch", {bus.out_valid, bus.count, bus.empty}, {1'b0, 3'd0, 1'b1});
    rec_btn = 1'b0;
    tick();
    rst = 1'b0;
    hist.delete();
    off = 0;
    do_write(9'h044);
    bus.out_ready = 1'b0;
    rec_btn       = 1'b1;
    repeat (4) tick();
    rec_btn = 1'b0;
    chk("pre_rst_present", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_present", {bus.out_valid, bus.count, bus.empty}, {1'b0, 3'd0, 1'b1});
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    hist.delete();
    off = 0;

`ifdef RECALL_CLEAR_EN
    do_write(9'h011);
    do_write(9'h022);
    clr         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 9'h099;
    tick();
    clr       = 1'b0;
    bus.wr_en = 1'b0;
    hist.delete();
    off = 0;
    chk("clr_wr", {bus.count, bus.empty, bus.out_valid}, {3'd0, 1'b1, 1'b0});
    do_write(9'h055);
    recall_expect("after_clr", 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
